send_seg_scheduler: RTL and testbench
=====================================

Name: send_seg_scheduler

Overview:
Send-pipe stage that decides when to emit the next TCP segment for one flow, and which bytes it carries. Tracks the app lead pointer, the peer ACK pointer, the peer window and the next-send pointer. Presents a window-limited pointer pair to the segment calculator and takes back its segment size. Issues segment requests (buffer pointer, length, sequence number) to the payload/header stage via a valid/ready handshake, and supports rewind for retransmission.

Parameters:
ptr_w, 12, send-buffer address width; buffer is 2^ptr_w bytes; all pointers are ptr_w+1 bits (extra wrap bit)
win_w, 16, peer advertised window width in bytes
INIT_SEQ, 32'h0, sequence number that corresponds to buffer pointer 0

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
lead_ptr_wr_val  input  1  app lead-pointer update strobe
lead_ptr_wr  input  ptr_w+1  new app lead pointer
ack_val  input  1  ACK update strobe from the receive pipe
ack_ptr  input  ptr_w+1  new cumulative-ACK buffer pointer
ack_win  input  win_w  peer window carried with that ACK
rt_req  input  1  retransmit request pulse (rewind to ACK pointer)
calc_trail_ptr  output  ptr_w+1  trail pointer to the segment calculator (= snd_nxt)
calc_lead_ptr  output  ptr_w+1  window-limited lead pointer to the segment calculator
calc_seg_size  input  ptr_w+1  segment size returned combinationally by the segment calculator
seg_req_val  output  1  segment request valid
seg_req_rdy  input  1  downstream ready
seg_req_ptr  output  ptr_w+1  buffer start pointer of the segment
seg_req_len  output  ptr_w+1  segment length in bytes
seg_req_seq  output  32  TCP sequence number of the first byte

Behaviour:
- Registers: lead_r, una_r (ACK ptr), win_r, snd_nxt, una_seq, nxt_seq, rt_pend, state, plus output holding registers. On reset, all are 0 except una_seq = nxt_seq = INIT_SEQ. State resets to IDLE, and all outputs are 0.
- Pointer arithmetic is modulo 2^(ptr_w+1), so wrap is handled implicitly. Upstream guarantees lead_r - una_r <= 2^ptr_w.
- Window: win_c = min(win_r, 2^ptr_w); inflight = snd_nxt - una_r; avail = (win_c > inflight) ? win_c - inflight : 0.
- Send limit: pend = lead_r - snd_nxt; calc_lead_ptr = snd_nxt + min(pend, avail); calc_trail_ptr = snd_nxt. Both are combinational from the registers.
- lead_ptr_wr_val loads lead_r in any state. The new value is visible to the calculator the following cycle.
- ack_val, in any state: ad = ack_ptr - una_r. una_r <= ack_ptr; una_seq += ad; win_r <= ack_win.
  - If the ACK passes snd_nxt (ad > inflight), snd_nxt <= ack_ptr and nxt_seq <= una_seq + ad.
  - In ISSUE, that snd_nxt correction is deferred until after the handshake.
- FSM:
  - IDLE:
    - If rt_pend or rt_req: snd_nxt <= una_r, nxt_seq <= una_seq, clear rt_pend, stay IDLE. This takes priority over issuing.
    - Else if calc_seg_size != 0: latch seg_req_ptr = snd_nxt, seg_req_len = calc_seg_size, seg_req_seq = nxt_seq; go to ISSUE.
  - ISSUE:
    - seg_req_val = 1. ptr, len and seq hold stable until seg_req_rdy.
    - rt_req in this state sets rt_pend.
    - On val&rdy: snd_nxt += len and nxt_seq += len; then apply any deferred ACK correction (re-evaluated against the new snd_nxt); go to IDLE.
- There is one bubble cycle in IDLE between issued segments, so at most one segment every 2 cycles.
- Zero window or no pending data: remain in IDLE with seg_req_val = 0.
- ack_val together with rt_req: the ACK updates una_r first, and the rewind uses the updated una_r / una_seq.
- Reset mid-ISSUE: seg_req_val drops the next cycle; no request is completed.

Test Plan:
- Reset with lead=0 -> seg_req_val stays 0 for 20 cycles; calc_trail_ptr = calc_lead_ptr = 0; seg_req_seq = 0.
- INIT_SEQ=1000; ack_win=1000, lead_ptr_wr=100, rdy=1 -> request ptr=0 len=96 seq=1000, then ptr=96 len=4 seq=1096; then idle.
- ack_win=40, lead=2000 -> len 32, then len 8; then no request until ack_val with ack_ptr=40 and ack_win=40, after which len 32 issues at ptr 40.
- seg_req_rdy held low 5 cycles during ISSUE -> val, ptr, len and seq are stable each cycle; exactly one transfer occurs on rdy.
- una=0, snd_nxt=96; rt_req pulsed during ISSUE of ptr 96 -> after handshake the FSM rewinds; the next request is ptr=0, seq=INIT_SEQ.
- Wrap with ptr_w=12: snd_nxt=una=4090, lead=4100, large window -> request ptr=4090 len=10; snd_nxt becomes 4100 with nxt_seq advanced by 10.

Source files
------------

// File: rtl/send_seg_scheduler.sv
// Per-flow send scheduler: window-limits the pending range for the segment
// calculator, issues segment requests downstream and rewinds for retransmit.
module send_seg_scheduler #(
   parameter int          ptr_w    = 12,
   parameter int          win_w    = 16,
   parameter logic [31:0] INIT_SEQ = 32'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lead_ptr_wr_val,
   input  logic [ptr_w:0]   lead_ptr_wr,
   input  logic             ack_val,
   input  logic [ptr_w:0]   ack_ptr,
   input  logic [win_w-1:0] ack_win,
   input  logic             rt_req,
   output logic [ptr_w:0]   calc_trail_ptr,
   output logic [ptr_w:0]   calc_lead_ptr,
   input  logic [ptr_w:0]   calc_seg_size,
   output logic             seg_req_val,
   input  logic             seg_req_rdy,
   output logic [ptr_w:0]   seg_req_ptr,
   output logic [ptr_w:0]   seg_req_len,
   output logic [31:0]      seg_req_seq
);

   localparam int PW = ptr_w + 1;
   localparam int CW = (win_w > PW) ? win_w : PW;

   typedef enum logic [0:0] {IDLE, ISSUE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    lead_q, lead_d;
   logic [PW-1:0]    una_q, una_d;
   logic [win_w-1:0] win_q, win_d;
   logic [PW-1:0]    snd_nxt_q, snd_nxt_d;
   logic [31:0]      una_seq_q, una_seq_d;
   logic [31:0]      nxt_seq_q, nxt_seq_d;
   logic             rt_pend_q, rt_pend_d;
   logic [PW-1:0]    seg_ptr_q, seg_ptr_d;
   logic [PW-1:0]    seg_len_q, seg_len_d;
   logic [31:0]      seg_seq_q, seg_seq_d;

   logic [CW-1:0]    win_ext, win_cap;
   logic [PW-1:0]    win_c, inflight, avail, pend;
   logic [PW-1:0]    ad, snd_adv, gap;
   logic [31:0]      seq_adv;
   logic             ack_pass;

   // Effective window is capped at the buffer size so it fits pointer width
   assign win_ext  = CW'(win_q);
   assign win_cap  = CW'(1) << ptr_w;
   assign win_c    = (win_ext > win_cap) ? win_cap[PW-1:0] : win_ext[PW-1:0];
   assign inflight = snd_nxt_q - una_q;
   assign avail    = (win_c > inflight) ? (win_c - inflight) : '0;
   assign pend     = lead_q - snd_nxt_q;

   assign calc_trail_ptr = snd_nxt_q;
   assign calc_lead_ptr  = snd_nxt_q + ((pend < avail) ? pend : avail);

   assign seg_req_val = (state_q == ISSUE);
   assign seg_req_ptr = seg_ptr_q;
   assign seg_req_len = seg_len_q;
   assign seg_req_seq = seg_seq_q;

   always_comb begin
      state_d   = state_q;
      lead_d    = lead_q;
      una_d     = una_q;
      win_d     = win_q;
      snd_nxt_d = snd_nxt_q;
      una_seq_d = una_seq_q;
      nxt_seq_d = nxt_seq_q;
      rt_pend_d = rt_pend_q;
      seg_ptr_d = seg_ptr_q;
      seg_len_d = seg_len_q;
      seg_seq_d = seg_seq_q;
      ad        = '0;
      snd_adv   = '0;
      gap       = '0;
      seq_adv   = '0;
      ack_pass  = 1'b0;

      if (lead_ptr_wr_val)
         lead_d = lead_ptr_wr;

      if (ack_val) begin
         ad        = ack_ptr - una_q;
         una_d     = ack_ptr;
         una_seq_d = una_seq_q + 32'(ad);
         win_d     = ack_win;
         ack_pass  = (ad > inflight);
      end

      case (state_q)
         IDLE: begin
            if (ack_pass) begin
               snd_nxt_d = ack_ptr;
               nxt_seq_d = una_seq_d;
            end
            if (rt_pend_q || rt_req) begin
               snd_nxt_d = una_d;
               nxt_seq_d = una_seq_d;
               rt_pend_d = 1'b0;
            end else if ((calc_seg_size != '0) && !ack_pass) begin
               // A passing ACK makes this cycle's calculator result stale
               seg_ptr_d = snd_nxt_q;
               seg_len_d = calc_seg_size;
               seg_seq_d = nxt_seq_q;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (rt_req)
               rt_pend_d = 1'b1;
            if (seg_req_rdy) begin
               snd_adv   = snd_nxt_q + seg_len_q;
               seq_adv   = nxt_seq_q + 32'(seg_len_q);
               snd_nxt_d = snd_adv;
               nxt_seq_d = seq_adv;
               // una strictly ahead of the advanced snd_nxt: jump forward
               gap = una_d - snd_adv;
               if ((gap != '0) && !gap[PW-1]) begin
                  snd_nxt_d = una_d;
                  nxt_seq_d = una_seq_d;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         lead_q    <= '0;
         una_q     <= '0;
         win_q     <= '0;
         snd_nxt_q <= '0;
         una_seq_q <= INIT_SEQ;
         nxt_seq_q <= INIT_SEQ;
         rt_pend_q <= 1'b0;
         seg_ptr_q <= '0;
         seg_len_q <= '0;
         seg_seq_q <= '0;
      end else begin
         state_q   <= state_d;
         lead_q    <= lead_d;
         una_q     <= una_d;
         win_q     <= win_d;
         snd_nxt_q <= snd_nxt_d;
         una_seq_q <= una_seq_d;
         nxt_seq_q <= nxt_seq_d;
         rt_pend_q <= rt_pend_d;
         seg_ptr_q <= seg_ptr_d;
         seg_len_q <= seg_len_d;
         seg_seq_q <= seg_seq_d;
      end
   end

endmodule

// File: tb/tb_send_seg_scheduler.sv
// Directed bench for send_seg_scheduler with a request scoreboard and a
// segment calculator that rounds to 32-byte multiples.
module tb_send_seg_scheduler;

   localparam int PW = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          lead_ptr_wr_val;
   logic [PW-1:0] lead_ptr_wr;
   logic          ack_val;
   logic [PW-1:0] ack_ptr;
   logic [15:0]   ack_win;
   logic          rt_req;
   logic [PW-1:0] calc_trail_ptr, calc_lead_ptr, calc_seg_size, calc_d;
   logic          seg_req_val, seg_req_rdy;
   logic [PW-1:0] seg_req_ptr, seg_req_len;
   logic [31:0]   seg_req_seq;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [PW-1:0] ptr;
      logic [PW-1:0] len;
      logic [31:0]   seq;
   } exp_t;
   exp_t q[$];

   send_seg_scheduler #(.ptr_w(12), .win_w(16), .INIT_SEQ(32'd1000)) dut (
      .clk(clk), .rst(rst),
      .lead_ptr_wr_val(lead_ptr_wr_val), .lead_ptr_wr(lead_ptr_wr),
      .ack_val(ack_val), .ack_ptr(ack_ptr), .ack_win(ack_win),
      .rt_req(rt_req),
      .calc_trail_ptr(calc_trail_ptr), .calc_lead_ptr(calc_lead_ptr),
      .calc_seg_size(calc_seg_size),
      .seg_req_val(seg_req_val), .seg_req_rdy(seg_req_rdy),
      .seg_req_ptr(seg_req_ptr), .seg_req_len(seg_req_len),
      .seg_req_seq(seg_req_seq)
   );

   always #5 clk = ~clk;

   always_comb begin
      calc_d        = calc_lead_ptr - calc_trail_ptr;
      calc_seg_size = (calc_d >= 13'd32) ? (calc_d & 13'h1FE0) : calc_d;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (seg_req_val && seg_req_rdy) begin
         if (q.size() == 0) begin
            chk("unexpected_req_ptr", {51'd0, seg_req_ptr}, 64'hFFFF);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("req_ptr", {51'd0, seg_req_ptr}, {51'd0, e.ptr});
            chk("req_len", {51'd0, seg_req_len}, {51'd0, e.len});
            chk("req_seq", {32'd0, seg_req_seq}, {32'd0, e.seq});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic set_lead(input logic [PW-1:0] p);
      lead_ptr_wr_val = 1'b1; lead_ptr_wr = p;
      cyc();
      lead_ptr_wr_val = 1'b0;
   endtask

   task automatic do_ack(input logic [PW-1:0] p, input logic [15:0] w);
      ack_val = 1'b1; ack_ptr = p; ack_win = w;
      cyc();
      ack_val = 1'b0;
   endtask

   task automatic push(input int p, input int l, input int s);
      exp_t e;
      e.ptr = PW'(p); e.len = PW'(l); e.seq = 32'(s);
      q.push_back(e);
   endtask

   task automatic wait_val(input int max);
      int n = 0;
      while (!seg_req_val && n < max) begin cyc(); n++; end
      chk("wait_val", {63'd0, seg_req_val}, 64'd1);
   endtask

   task automatic drain(input int max);
      int n = 0;
      while (q.size() != 0 && n < max) begin cyc(); n++; end
      chk("drain_left", 64'(q.size()), 64'd0);
   endtask

   initial begin
      rst = 1'b1; lead_ptr_wr_val = 1'b0; lead_ptr_wr = '0;
      ack_val = 1'b0; ack_ptr = '0; ack_win = '0; rt_req = 1'b0; seg_req_rdy = 1'b0;

      // Reset state, no data
      do_reset();
      chk("rst_trail", {51'd0, calc_trail_ptr}, 64'd0);
      chk("rst_lead", {51'd0, calc_lead_ptr}, 64'd0);
      chk("rst_seq", {32'd0, seg_req_seq}, 64'd0);
      seg_req_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("idle_val", {63'd0, seg_req_val}, 64'd0);
         cyc();
      end

      // Basic issue: 96 then 4
      do_ack(13'd0, 16'd1000);
      push(0, 96, 1000); push(96, 4, 1096);
      set_lead(13'd100);
      drain(40);
      repeat (6) cyc();
      chk("basic_trail", {51'd0, calc_trail_ptr}, 64'd100);
      chk("basic_val", {63'd0, seg_req_val}, 64'd0);

      // Window-limited, then reopened by ACK
      do_reset();
      do_ack(13'd0, 16'd40);
      push(0, 32, 1000); push(32, 8, 1032);
      set_lead(13'd2000);
      drain(40);
      repeat (10) cyc();
      chk("win_trail", {51'd0, calc_trail_ptr}, 64'd40);
      chk("win_lead", {51'd0, calc_lead_ptr}, 64'd40);
      chk("win_val", {63'd0, seg_req_val}, 64'd0);
      push(40, 32, 1040); push(72, 8, 1072);
      do_ack(13'd40, 16'd40);
      drain(40);
      repeat (6) cyc();
      chk("win2_trail", {51'd0, calc_trail_ptr}, 64'd80);

      // Backpressure: request stable while rdy low
      do_reset();
      seg_req_rdy = 1'b0;
      do_ack(13'd0, 16'd1000);
      set_lead(13'd64);
      wait_val(20);
      for (int i = 0; i < 5; i++) begin
         chk("stall_val", {63'd0, seg_req_val}, 64'd1);
         chk("stall_ptr", {51'd0, seg_req_ptr}, 64'd0);
         chk("stall_len", {51'd0, seg_req_len}, 64'd64);
         chk("stall_seq", {32'd0, seg_req_seq}, 64'd1000);
         cyc();
      end
      push(0, 64, 1000);
      seg_req_rdy = 1'b1;
      drain(10);
      seg_req_rdy = 1'b0;
      repeat (4) cyc();
      chk("stall_after_val", {63'd0, seg_req_val}, 64'd0);
      chk("stall_trail", {51'd0, calc_trail_ptr}, 64'd64);

      // Reset during ISSUE drops the request
      set_lead(13'd128);
      wait_val(20);
      chk("mid_ptr", {51'd0, seg_req_ptr}, 64'd64);
      rst = 1'b1;
      cyc();
      chk("mid_rst_val", {63'd0, seg_req_val}, 64'd0);
      chk("mid_rst_ptr", {51'd0, seg_req_ptr}, 64'd0);
      cyc();
      rst = 1'b0;

      // Retransmit request during ISSUE of ptr 96
      do_ack(13'd0, 16'd1000);
      push(0, 96, 1000); push(96, 4, 1096); push(0, 96, 1000); push(96, 4, 1096);
      set_lead(13'd100);
      wait_val(20);
      seg_req_rdy = 1'b1;
      cyc();
      seg_req_rdy = 1'b0;
      wait_val(20);
      chk("rt_issue_ptr", {51'd0, seg_req_ptr}, 64'd96);
      rt_req = 1'b1;
      cyc();
      rt_req = 1'b0;
      seg_req_rdy = 1'b1;
      drain(40);
      repeat (4) cyc();
      chk("rt_trail", {51'd0, calc_trail_ptr}, 64'd100);

      // Buffer wrap near 4096
      do_reset();
      set_lead(13'd4090);
      do_ack(13'd4090, 16'd0);
      chk("wrap_snd", {51'd0, calc_trail_ptr}, 64'd4090);
      set_lead(13'd4100);
      push(4090, 10, 5090);
      do_ack(13'd4090, 16'd5000);
      drain(20);
      repeat (3) cyc();
      chk("wrap_trail", {51'd0, calc_trail_ptr}, 64'd4100);
      push(4100, 10, 5100);
      set_lead(13'd4110);
      drain(20);
      repeat (4) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
